mod_shift_preprocess: RTL

//  Computes T = (M * 2^K) mod N by K iterations of modular doubling: double, then subtract N if result >= N.

---
 rtl/pp_pkg.sv | 12 +
 rtl/mod_dbl_step.sv | 22 ++
 rtl/mod_shift_preprocess.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pp_pkg.sv
// Shared types and default sizes for the modular shift preprocess block.
package pp_pkg;

    typedef enum logic {
        PP_IDLE,
        PP_RUN
    } pp_state_t;

    localparam int unsigned PP_WIDTH_DEF = 256;
    localparam int unsigned PP_KW_DEF    = 10;

endpackage

// File: rtl/mod_dbl_step.sv
// One modular doubling step: y = (2x >= n) ? 2x - n : 2x, assuming x < n.
module mod_dbl_step
    import pp_pkg::*;
#(
    parameter int unsigned WIDTH = PP_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH:0] d;
    logic [WIDTH:0] n_ext;

    always_comb begin
        d     = {x, 1'b0};
        n_ext = {1'b0, n};
        // x < n keeps d < 2n, so a single conditional subtract lands below n
        y     = (d >= n_ext) ? WIDTH'(d - n_ext) : d[WIDTH-1:0];
    end

endmodule

// File: rtl/mod_shift_preprocess.sv
// T = (M * 2^K) mod N by K modular doublings; PP_RADIX4_EN chains two doublings per cycle.
module mod_shift_preprocess
    import pp_pkg::*;
#(
    parameter int unsigned WIDTH = PP_WIDTH_DEF,
    parameter int unsigned KW    = PP_KW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] n_i,
    input  logic [WIDTH-1:0] m_i,
    input  logic [KW-1:0]    k_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [WIDTH-1:0] t_o
);

    pp_state_t        state, state_nx;
    logic [WIDTH-1:0] n_q, n_nx;
    logic [WIDTH-1:0] temp, temp_nx;
    logic [WIDTH-1:0] t_nx;
    logic [KW-1:0]    cnt, cnt_nx;
    logic             err_nx;
    logic             done_nx;
    logic [WIDTH-1:0] step1;

    mod_dbl_step #(.WIDTH(WIDTH)) u_step1 (
        .x (temp),
        .n (n_q),
        .y (step1)
    );

`ifdef PP_RADIX4_EN
    logic [WIDTH-1:0] step2;

    mod_dbl_step #(.WIDTH(WIDTH)) u_step2 (
        .x (step1),
        .n (n_q),
        .y (step2)
    );
`endif

    assign busy_o = (state == PP_RUN);

    always_comb begin
        state_nx = state;
        n_nx     = n_q;
        temp_nx  = temp;
        cnt_nx   = cnt;
        t_nx     = t_o;
        err_nx   = err_o;
        done_nx  = 1'b0;
        case (state)
            PP_IDLE: begin
                if (start_i) begin
                    n_nx    = n_i;
                    temp_nx = m_i;
                    cnt_nx  = k_i;
                    err_nx  = 1'b0;
                    if ((n_i == '0) || (m_i >= n_i)) begin
                        err_nx  = 1'b1;
                        t_nx    = '0;
                        done_nx = 1'b1;
                    end else if (k_i == '0) begin
                        t_nx    = m_i;
                        done_nx = 1'b1;
                    end else begin
                        state_nx = PP_RUN;
                    end
                end
            end
            PP_RUN: begin
`ifdef PP_RADIX4_EN
                // an odd count leaves a single step for the final cycle
                if (cnt == KW'(1)) begin
                    temp_nx  = step1;
                    cnt_nx   = '0;
                    t_nx     = step1;
                    done_nx  = 1'b1;
                    state_nx = PP_IDLE;
                end else begin
                    temp_nx = step2;
                    cnt_nx  = cnt - KW'(2);
                    if (cnt == KW'(2)) begin
                        t_nx     = step2;
                        done_nx  = 1'b1;
                        state_nx = PP_IDLE;
                    end
                end
`else
                temp_nx = step1;
                cnt_nx  = cnt - KW'(1);
                if (cnt == KW'(1)) begin
                    t_nx     = step1;
                    done_nx  = 1'b1;
                    state_nx = PP_IDLE;
                end
`endif
            end
            default: state_nx = PP_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= PP_IDLE;
            n_q    <= '0;
            temp   <= '0;
            cnt    <= '0;
            t_o    <= '0;
            err_o  <= 1'b0;
            done_o <= 1'b0;
        end else begin
            state  <= state_nx;
            n_q    <= n_nx;
            temp   <= temp_nx;
            cnt    <= cnt_nx;
            t_o    <= t_nx;
            err_o  <= err_nx;
            done_o <= done_nx;
        end
    end

endmodule
